mem_io_responder: RTL and testbench



---
 rtl/mem_io_responder.sv | 190 +++++++++++++++++++
 tb/tb_mem_io_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the byte-wide CPU memory bus.
// It serves RAM at cpu_a[ADDR_WIDTH-1:0] and a UART window at 0x30000-0x3FFFF
// (TX FIFO push/RX byte at +0, halt/status at +4), with one-cycle read latency.
module mem_io_responder #(
  parameter int    ADDR_WIDTH    = 17,
  parameter int    TX_DEPTH_LOG2 = 3,
  parameter int    FULL_MARGIN   = 2,
  parameter string INIT_FILE     = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        halt
);

  localparam int                     TX_DEPTH    = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] DEPTH_COUNT = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);
  localparam logic [TX_DEPTH_LOG2:0] FULL_THRESH = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH - FULL_MARGIN);

  // Only the low 18 address bits take part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, cpu_a[31:18]};

  // Address decode and qualified bus strobes (everything CPU-side is gated by rdy_in).
  logic                  is_io;
  logic                  sel_data;
  logic                  sel_ctrl;
  logic                  cpu_wr_en;
  logic                  cpu_rd_en;
  logic [ADDR_WIDTH-1:0] ram_addr;

  assign is_io     = (cpu_a[17:16] == 2'b11);
  assign sel_data  = is_io && (cpu_a[15:0] == 16'h0000);
  assign sel_ctrl  = is_io && (cpu_a[15:0] == 16'h0004);
  assign cpu_wr_en = rdy_in && cpu_wr;
  assign cpu_rd_en = rdy_in && !cpu_wr;
  assign ram_addr  = cpu_a[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------- RAM
  logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];
  logic [7:0] ram_q_reg;

  // Block RAM port: write and registered read; no reset so it maps onto a RAM primitive.
  always_ff @(posedge clk_in) begin
    if (cpu_wr_en && !is_io) begin
      ram[ram_addr] <= cpu_dout;
    end
    if (cpu_rd_en && !is_io) begin
      ram_q_reg <= ram[ram_addr];
    end
  end

  // ---------------------------------------------------------------- RX holding register
  logic       rx_held_valid_reg;
  logic [7:0] rx_held_reg;

  assign rx_ready = !rx_held_valid_reg;

  // Host capture when empty; a CPU read of the data port empties it (takes priority).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_held_valid_reg <= 1'b0;
      rx_held_reg       <= 8'h00;
    end else if (rx_held_valid_reg) begin
      if (cpu_rd_en && sel_data) begin
        rx_held_valid_reg <= 1'b0;
      end
    end else if (rx_valid) begin
      rx_held_valid_reg <= 1'b1;
      rx_held_reg       <= rx_data;
    end
  end

  // ---------------------------------------------------------------- read-data path
  logic [7:0] io_rd_data;
  logic [7:0] io_q_reg;
  logic       din_from_ram_reg;

  // IO read value for the current address.
  always_comb begin
    io_rd_data = 8'h00;
    if (sel_data && rx_held_valid_reg) begin
      io_rd_data = rx_held_reg;
    end else if (sel_ctrl) begin
      io_rd_data = {7'b0, rx_held_valid_reg};
    end
  end

  // Remember which source the last read came from; both sources hold on non-read cycles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      io_q_reg         <= 8'h00;
      din_from_ram_reg <= 1'b0;
    end else if (cpu_rd_en) begin
      io_q_reg         <= io_rd_data;
      din_from_ram_reg <= !is_io;
    end
  end

  assign cpu_din = din_from_ram_reg ? ram_q_reg : io_q_reg;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]               tx_mem [0:TX_DEPTH-1];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [TX_DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [TX_DEPTH_LOG2:0]   count_reg;
  logic [TX_DEPTH_LOG2:0]   count_next;
  logic                     io_full_reg;
  logic                     overflow_reg;
  logic                     tx_push_req;
  logic                     tx_push;
  logic                     tx_pop;

  assign tx_valid    = (count_reg != '0);
  assign tx_data     = tx_mem[rd_ptr_reg];
  assign tx_pop      = tx_valid && tx_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign tx_push_req = cpu_wr_en && sel_data;
  assign tx_push     = tx_push_req && ((count_reg != DEPTH_COUNT) || tx_pop);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count_reg;
    if (tx_push && !tx_pop) begin
      count_next = count_reg + 1'b1;
    end else if (tx_pop && !tx_push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // FIFO storage write at the tail.
  always_ff @(posedge clk_in) begin
    if (tx_push && !rst_in) begin
      tx_mem[wr_ptr_reg] <= cpu_dout;
    end
  end

  // FIFO pointers, occupancy, near-full flag and sticky overflow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      io_full_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (tx_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (tx_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg   <= count_next;
      io_full_reg <= (count_next >= FULL_THRESH);
      if (tx_push_req && !tx_push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign io_buffer_full = io_full_reg;
  assign tx_overflow    = overflow_reg;

  // ---------------------------------------------------------------- halt port
  logic halt_reg;

  // Sticky halt, set by any write to the control port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      halt_reg <= 1'b0;
    end else if (cpu_wr_en && sel_ctrl) begin
      halt_reg <= 1'b1;
    end
  end

  assign halt = halt_reg;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed stimulus against mem_io_responder with a
// transaction-level reference model checked every cycle, plus literal checks.
module tb_mem_io_responder;

  localparam logic [31:0] IDLE_A = 32'h0003_0008;
  localparam logic [31:0] DATA_A = 32'h0003_0000;
  localparam logic [31:0] CTRL_A = 32'h0003_0004;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        tx_overflow;
  logic        halt;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_overflow    (tx_overflow),
    .halt           (halt)
  );

  always #5 clk_in = ~clk_in;

  int         n_vec = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b0;
  logic [7:0] got[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  bit [7:0] m_ram [int];
  bit [7:0] m_q[$];
  bit       m_rxv;
  bit [7:0] m_rx;
  bit       m_halt;
  bit       m_ovf;
  bit       m_full;
  bit [7:0] m_din;
  bit       m_din_known;

  always @(posedge clk_in) begin : model
    bit [17:0] a;
    bit        io;
    bit        pop;
    bit        rd0;
    a  = cpu_a[17:0];
    io = (a[17:16] == 2'b11);
    if (rdy_in && cpu_wr && !io) m_ram[int'(a[16:0])] = cpu_dout;
    if (rst_in) begin
      m_q.delete();
      m_rxv = 1'b0; m_rx = 8'h00; m_halt = 1'b0; m_ovf = 1'b0;
      m_full = 1'b0; m_din = 8'h00; m_din_known = 1'b1;
    end else begin
      pop = (m_q.size() > 0) && tx_ready;
      rd0 = rdy_in && !cpu_wr && (a == 18'h30000);
      if (rdy_in && !cpu_wr) begin
        if (io) begin
          m_din_known = 1'b1;
          if (a == 18'h30000)      m_din = m_rxv ? m_rx : 8'h00;
          else if (a == 18'h30004) m_din = {7'b0, m_rxv};
          else                     m_din = 8'h00;
        end else if (m_ram.exists(int'(a[16:0]))) begin
          m_din = m_ram[int'(a[16:0])];
          m_din_known = 1'b1;
        end else begin
          m_din_known = 1'b0;
        end
      end
      if (m_rxv) begin
        if (rd0) m_rxv = 1'b0;
      end else if (rx_valid) begin
        m_rxv = 1'b1;
        m_rx  = rx_data;
      end
      if (pop) void'(m_q.pop_front());
      if (rdy_in && cpu_wr && a == 18'h30000) begin
        if (m_q.size() < 8) m_q.push_back(cpu_dout);
        else m_ovf = 1'b1;
      end
      if (rdy_in && cpu_wr && a == 18'h30004) m_halt = 1'b1;
      m_full = (m_q.size() >= 6);
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      check1("m_tx_valid", tx_valid, m_q.size() != 0);
      if (m_q.size() != 0) check8("m_tx_data", tx_data, m_q[0]);
      check1("m_rx_ready", rx_ready, !m_rxv);
      check1("m_io_full", io_buffer_full, m_full);
      check1("m_overflow", tx_overflow, m_ovf);
      check1("m_halt", halt, m_halt);
      if (m_din_known) check8("m_cpu_din", cpu_din, m_din);
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic tick();
    if (tx_valid && tx_ready && !rst_in) got.push_back(tx_data);
    @(negedge clk_in);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_a = a; cpu_dout = d;
    tick();
    $display("wr a=%05h d=%02h full=%b ovf=%b", a[17:0], d, io_buffer_full, tx_overflow);
    cpu_wr = 1'b0; cpu_a = IDLE_A;
  endtask

  task automatic do_rd(input logic [31:0] a);
    cpu_wr = 1'b0; cpu_a = a;
    tick();
    $display("rd a=%05h din=%02h", a[17:0], cpu_din);
    cpu_a = IDLE_A;
  endtask

  // ------------------------------------------------------------ directed sequence
  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; cpu_wr = 1'b0; cpu_a = IDLE_A; cpu_dout = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick();
    chk_en = 1'b1;
    tick();
    check8("rst_din", cpu_din, 8'h00);
    check1("rst_tx_valid", tx_valid, 1'b0);
    check1("rst_rx_ready", rx_ready, 1'b1);
    check1("rst_io_full", io_buffer_full, 1'b0);
    check1("rst_overflow", tx_overflow, 1'b0);
    check1("rst_halt", halt, 1'b0);
    rst_in = 1'b0;

    // RAM round trip, back-to-back reads
    do_wr(32'h100, 8'h11); do_wr(32'h101, 8'h22); do_wr(32'h102, 8'h33); do_wr(32'h103, 8'h44);
    do_rd(32'h100); check8("ram_rd0", cpu_din, 8'h11);
    do_rd(32'h101); check8("ram_rd1", cpu_din, 8'h22);
    do_rd(32'h102); check8("ram_rd2", cpu_din, 8'h33);
    do_rd(32'h103); check8("ram_rd3", cpu_din, 8'h44);

    // Fill to full, then push+pop at full twice; pointers wrap here
    got.delete();
    for (int i = 0; i < 8; i++) do_wr(DATA_A, 8'(8'hB0 + i));
    check1("full_io_full", io_buffer_full, 1'b1);
    tx_ready = 1'b1;
    do_wr(DATA_A, 8'hB8);
    check1("pp_ovf0", tx_overflow, 1'b0);
    check1("pp_io_full0", io_buffer_full, 1'b1);
    check8("pp_head0", tx_data, 8'hB1);
    do_wr(DATA_A, 8'hB9);
    check1("pp_ovf1", tx_overflow, 1'b0);
    check8("pp_head1", tx_data, 8'hB2);
    for (int i = 0; i < 15 && tx_valid; i++) tick();
    check1("pp_drain_done", tx_valid, 1'b0);
    check8("pp_count", 8'(got.size()), 8'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) check8("pp_order", got[i], 8'(8'hB0 + i));
    tx_ready = 1'b0;

    // Threshold and overflow
    got.delete();
    for (int i = 1; i <= 9; i++) begin
      do_wr(DATA_A, 8'(8'hA0 + i));
      if (i == 5) check1("thr_below", io_buffer_full, 1'b0);
      if (i == 6) check1("thr_rise", io_buffer_full, 1'b1);
      if (i == 8) check1("ovf_not_yet", tx_overflow, 1'b0);
      if (i == 9) check1("ovf_set", tx_overflow, 1'b1);
    end
    check8("ovf_head", tx_data, 8'hA1);
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 8) check1("thr_fall", io_buffer_full, (i < 2));
    end
    check8("ovf_count", 8'(got.size()), 8'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) check8("ovf_order", got[i], 8'(8'hA1 + i));
    check1("ovf_sticky", tx_overflow, 1'b1);
    tx_ready = 1'b0;

    // RX path
    rx_data = 8'h5A; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    check1("rx_captured", rx_ready, 1'b0);
    do_rd(CTRL_A); check8("rx_status1", cpu_din, 8'h01);
    do_rd(DATA_A); check8("rx_data", cpu_din, 8'h5A);
    check1("rx_cleared", rx_ready, 1'b1);
    do_rd(CTRL_A); check8("rx_status0", cpu_din, 8'h00);
    do_rd(32'h101);
    do_rd(DATA_A); check8("rx_empty_rd", cpu_din, 8'h00);
    // read and new offer in the same cycle
    rx_data = 8'h77; rx_valid = 1'b1; tick();
    rx_data = 8'h88;
    do_rd(DATA_A); check8("rx_same_rd", cpu_din, 8'h77);
    check1("rx_same_not_taken", rx_ready, 1'b1);
    tick(); rx_valid = 1'b0;
    check1("rx_next_taken", rx_ready, 1'b0);
    do_rd(DATA_A); check8("rx_second", cpu_din, 8'h88);

    // rdy_in freeze: CPU side frozen, TX drain and RX capture continue
    do_wr(32'h200, 8'h5C);
    do_wr(DATA_A, 8'hC1);
    do_rd(32'h100);
    rdy_in = 1'b0; cpu_wr = 1'b1; cpu_a = 32'h200; cpu_dout = 8'hEE;
    tx_ready = 1'b1; rx_data = 8'h3C; rx_valid = 1'b1;
    tick();
    check8("frz_din0", cpu_din, 8'h11);
    check1("frz_tx_drain", tx_valid, 1'b0);
    check1("frz_rx_capture", rx_ready, 1'b0);
    tx_ready = 1'b0; rx_valid = 1'b0; cpu_a = CTRL_A;
    tick();
    check1("frz_halt", halt, 1'b0);
    check8("frz_din1", cpu_din, 8'h11);
    cpu_wr = 1'b0; cpu_a = DATA_A;
    tick();
    check1("frz_no_rx_clear", rx_ready, 1'b0);
    rdy_in = 1'b1; cpu_a = IDLE_A;
    do_rd(32'h200); check8("frz_ram_kept", cpu_din, 8'h5C);
    do_rd(DATA_A); check8("frz_rx_byte", cpu_din, 8'h3C);
    do_wr(CTRL_A, 8'h00); check1("halt_set", halt, 1'b1);

    // Reset mid-operation
    for (int i = 1; i <= 6; i++) do_wr(DATA_A, 8'(8'hD0 + i));
    rx_data = 8'h99; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    check1("mid_full", io_buffer_full, 1'b1);
    check1("mid_rx_held", rx_ready, 1'b0);
    rst_in = 1'b1; cpu_wr = 1'b1; cpu_a = 32'h300; cpu_dout = 8'h42;
    tick();
    check1("mr_tx_valid", tx_valid, 1'b0);
    check1("mr_rx_ready", rx_ready, 1'b1);
    check1("mr_io_full", io_buffer_full, 1'b0);
    check1("mr_halt", halt, 1'b0);
    check8("mr_din", cpu_din, 8'h00);
    cpu_a = DATA_A; cpu_dout = 8'hFF;
    tick();
    rst_in = 1'b0; cpu_wr = 1'b0; cpu_a = IDLE_A;
    tick();
    check1("mr_push_dropped", tx_valid, 1'b0);
    do_rd(32'h300); check8("mr_ram_write", cpu_din, 8'h42);
    do_rd(32'h100); check8("mr_ram_kept", cpu_din, 8'h11);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
